// File: rtl/hyperbus_cfg_req_buffer.sv
// ---------------------------------------------------------------------------
// hyperbus_cfg_req_buffer
//
// One-deep register-bus request buffer placed in front of the HyperBus
// configuration register file. The config block may hold ready low while a
// HyperBus transfer is in flight. This buffer captures one upstream request
// and presents it unchanged downstream until it is accepted. It then returns
// the registered response upstream for exactly one cycle.
//
// FSM: IDLE -> HOLD -> RESP -> IDLE.
//
// Optional feature, enabled by defining the macro HYPERBUS_CFG_BUF_TIMEOUT_EN:
//   A HOLD-cycle counter turns an access that stalls for TimeoutCycles cycles
//   into an error response and pulses timeout_o. With the macro undefined,
//   HOLD waits for ready indefinitely and timeout_o is tied low.
// ---------------------------------------------------------------------------

package hyperbus_cfg_req_buffer_pkg;

    // Default register-bus request, 32-bit address and data.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    // Default register-bus response, 32-bit data.
    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

module hyperbus_cfg_req_buffer #(
    parameter int unsigned RegAddrWidth  = 32,
    parameter int unsigned RegDataWidth  = 32,
    parameter type         reg_req_t     = hyperbus_cfg_req_buffer_pkg::reg_req_t,
    parameter type         reg_rsp_t     = hyperbus_cfg_req_buffer_pkg::reg_rsp_t,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output reg_req_t reg_req_o,
    input  reg_rsp_t reg_rsp_i,
    output logic     busy_o,
    output logic     timeout_o
);

    localparam int unsigned StrbWidth = RegDataWidth / 8;

    // Reject parameter sets the buffer is not built for.
    if ((RegDataWidth < 16) || ((RegDataWidth & (RegDataWidth - 1)) != 0)) begin : g_bad_data_width
        $error("hyperbus_cfg_req_buffer: RegDataWidth must be a power of two >= 16");
    end
    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("hyperbus_cfg_req_buffer: TimeoutCycles must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;

    // Holding registers for the captured request.
    logic [RegAddrWidth-1:0] addr_q,  addr_d;
    logic                    write_q, write_d;
    logic [RegDataWidth-1:0] wdata_q, wdata_d;
    logic [StrbWidth-1:0]    wstrb_q, wstrb_d;

    // Response registers, only visible upstream while in RESP.
    logic [RegDataWidth-1:0] rdata_q, rdata_d;
    logic                    error_q, error_d;

`ifdef HYPERBUS_CFG_BUF_TIMEOUT_EN
    localparam int unsigned           CntWidth    = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0]   TimeoutLast = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
`endif

    // Next-state logic: capture in IDLE, wait for ready (or timeout) in HOLD,
    // return to IDLE after the single RESP cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        error_d = error_q;
`ifdef HYPERBUS_CFG_BUF_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (reg_req_i.valid) begin
                    addr_d  = reg_req_i.addr;
                    write_d = reg_req_i.write;
                    wdata_d = reg_req_i.wdata;
                    wstrb_d = reg_req_i.wstrb;
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end

            HOLD: begin
                // A real response always beats a coincident timeout.
                if (reg_rsp_i.ready) begin
                    rdata_d = reg_rsp_i.rdata;
                    error_d = reg_rsp_i.error;
                    state_d = RESP;
                end
`ifdef HYPERBUS_CFG_BUF_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    rdata_d   = {RegDataWidth{1'b0}};
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d   = cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
                    state_d = HOLD;
                end
`else
                else begin
                    state_d = HOLD;
                end
`endif
            end

            RESP: begin
                state_d = IDLE;
`ifdef HYPERBUS_CFG_BUF_TIMEOUT_EN
                cnt_d   = {CntWidth{1'b0}};
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, holding and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= {RegAddrWidth{1'b0}};
            write_q <= 1'b0;
            wdata_q <= {RegDataWidth{1'b0}};
            wstrb_q <= {StrbWidth{1'b0}};
            rdata_q <= {RegDataWidth{1'b0}};
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

`ifdef HYPERBUS_CFG_BUF_TIMEOUT_EN
    // HOLD-cycle counter and the registered timeout pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= {CntWidth{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Downstream request: the captured fields, valid only while holding.
    always_comb begin
        reg_req_o       = '0;
        reg_req_o.addr  = addr_q;
        reg_req_o.write = write_q;
        reg_req_o.wdata = wdata_q;
        reg_req_o.wstrb = wstrb_q;
        reg_req_o.valid = (state_q == HOLD);
    end

    // Upstream response: data and error are masked to zero outside RESP.
    always_comb begin
        reg_rsp_o = '0;
        if (state_q == RESP) begin
            reg_rsp_o.ready = 1'b1;
            reg_rsp_o.rdata = rdata_q;
            reg_rsp_o.error = error_q;
        end else begin
            reg_rsp_o.ready = 1'b0;
        end
    end

    assign busy_o = (state_q == HOLD) || (state_q == RESP);

endmodule
